// File: rtl/load_store_unit_if.sv
// Core/memory-side signal bundle for the load/store unit.
// The slave modport is the LSU's view; the master modport is the core plus data_memory.
interface load_store_unit_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Core response channel
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    // data_memory channel
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_raddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_we, mem_waddr, mem_raddr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_we, mem_waddr, mem_raddr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: maps RV32 byte/half/word accesses onto a word-wide, sync-read data
// memory without byte enables. Sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLdWait,
        StRmwRd,
        StRmwWr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        misaligned;
    logic        illegal;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Request validity checks, evaluated on the live request in IDLE
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (bus.req_we) begin
            illegal = (bus.req_funct3 >= 3'd3);
        end else begin
            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                      (bus.req_funct3 == 3'd7);
        end
        out_of_range = ({2'b00, bus.req_addr[31:2]} >= MEM_SIZE);
        req_err      = misaligned | illegal | out_of_range;
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        case (addr_q[1:0])
            2'd0:    lane_b = bus.mem_rdata[7:0];
            2'd1:    lane_b = bus.mem_rdata[15:8];
            2'd2:    lane_b = bus.mem_rdata[23:16];
            default: lane_b = bus.mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q[1:0])
            2'd0:    load_data = funct3_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_data = funct3_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Merge captured store byte/half into the word read back from memory
    always_comb begin
        merge_data = bus.mem_rdata;
        if (funct3_q[0]) begin
            if (addr_q[1]) merge_data[31:16] = wdata_q;
            else           merge_data[15:0]  = wdata_q;
        end else begin
            case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Next-state, capture and memory-side outputs; memory ports are combinational
    // because data_memory samples them on the same edge
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        wdata_d       = wdata_q;
        merged_d      = merged_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        bus.req_ready = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_waddr = {addr_q[31:2], 2'b00};
        bus.mem_raddr = {addr_q[31:2], 2'b00};
        bus.mem_wdata = merged_q;
        accept        = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = rst_n;
                bus.mem_raddr = {bus.req_addr[31:2], 2'b00};
                accept        = bus.req_valid & rst_n;
                if (accept) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata[15:0];
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (bus.req_we) begin
                        if (bus.req_funct3 == 3'd2) begin
                            // Full-word store goes straight to memory this edge
                            bus.mem_we    = 1'b1;
                            bus.mem_waddr = bus.req_addr;
                            bus.mem_wdata = bus.req_wdata;
                            resp_valid_d  = 1'b1;
                            resp_rdata_d  = 32'h0;
                        end else begin
                            state_d = StRmwRd;
                        end
                    end else begin
                        state_d = StLdWait;
                    end
                end
            end
            StLdWait: begin
                resp_rdata_d = load_data;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StRmwRd: begin
                merged_d = merge_data;
                state_d  = StRmwWr;
            end
            StRmwWr: begin
                bus.mem_we   = 1'b1;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and response registers; reset aborts any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= 32'h0;
            funct3_q     <= 3'h0;
            wdata_q      <= 16'h0;
            merged_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            merged_q     <= merged_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, response scoreboard with cycle stamps,
// and one task per scenario.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   we_cnt;
    int   resp_cnt;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[0:1023];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_SIZE(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read word memory and store-pulse counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we) begin
            mem[bus.mem_waddr[11:2]] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        bus.mem_rdata <= mem[bus.mem_raddr[11:2]];
    end

    // Response monitor: pop scoreboard on each pulse
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            exp_t e;
            resp_cnt = resp_cnt + 1;
            if (sb.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_resp: got resp_valid=1 want no response (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                total = total + 3;
                if (bus.resp_err !== e.err) begin
                    bad = bad + 1;
                    $display("FAIL resp_err: got %0b want %0b", bus.resp_err, e.err);
                end
                if (bus.resp_rdata !== e.rdata) begin
                    bad = bad + 1;
                    $display("FAIL resp_rdata: got %08h want %08h", bus.resp_rdata, e.rdata);
                end
                if (cyc !== e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL resp_cycle: got %0d want %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                        input int lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL ready_timeout: got req_ready=0 want 1 within 20 cycles");
        end else begin
            bus.req_valid  = 1'b1;
            bus.req_we     = we;
            bus.req_funct3 = f3;
            bus.req_addr   = a;
            bus.req_wdata  = wd;
            e.err   = exp_err;
            e.rdata = exp_rd;
            e.cyc   = cyc + lat;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d pending responses want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h1111_1111;
        repeat (2) @(negedge clk);
        total = total + 5;
        if (bus.req_ready !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_ready: got %0b want 0", bus.req_ready);
        end
        if (bus.resp_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid);
        end
        if (bus.resp_err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_resp_err: got %0b want 0", bus.resp_err);
        end
        if (bus.resp_rdata !== 32'h0) begin
            bad = bad + 1;
            $display("FAIL reset_resp_rdata: got %08h want 00000000", bus.resp_rdata);
        end
        if (bus.mem_we !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we);
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total = total + 1;
        if (we_cnt !== 0) begin
            bad = bad + 1;
            $display("FAIL reset_no_write: got %0d writes want 0", we_cnt);
        end
    endtask

    task automatic test_sw_lw();
        int w0;
        w0 = we_cnt;
        send(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1);
        drain();
        total = total + 2;
        if (we_cnt - w0 !== 1) begin
            bad = bad + 1;
            $display("FAIL sw_we_pulses: got %0d want 1", we_cnt - w0);
        end
        if (mem[4] !== 32'hDEAD_BEEF) begin
            bad = bad + 1;
            $display("FAIL sw_mem: got %08h want deadbeef", mem[4]);
        end
        send(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
        drain();
    endtask

    task automatic test_load_ext();
        int w0;
        w0 = we_cnt;
        send(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, 2);
        send(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, 2);
        send(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD, 2);
        send(1'b0, 3'd5, 32'h10, 32'h0, 1'b0, 32'h0000_BEEF, 2);
        send(1'b0, 3'd0, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFEF, 2);
        drain();
        total = total + 1;
        if (we_cnt !== w0) begin
            bad = bad + 1;
            $display("FAIL load_no_write: got %0d writes want 0", we_cnt - w0);
        end
    endtask

    task automatic test_rmw();
        logic [15:0] sh_data[2];
        logic [31:0] addrs[2];
        logic [2:0]  f3s[2];
        logic [31:0] want[2];
        sh_data[0] = 16'h00AA; addrs[0] = 32'h11; f3s[0] = 3'd0; want[0] = 32'hDEAD_AAEF;
        sh_data[1] = 16'h1234; addrs[1] = 32'h12; f3s[1] = 3'd1; want[1] = 32'h1234_AAEF;
        for (int i = 0; i < 2; i++) begin
            int w0;
            w0 = we_cnt;
            send(1'b1, f3s[i], addrs[i], {16'h0, sh_data[i]}, 1'b0, 32'h0, 3);
            @(negedge clk);
            total = total + 1;
            if (bus.req_ready !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL rmw_ready_c1[%0d]: got %0b want 0", i, bus.req_ready);
            end
            @(negedge clk);
            total = total + 1;
            if (bus.req_ready !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL rmw_ready_c2[%0d]: got %0b want 0", i, bus.req_ready);
            end
            @(negedge clk);
            total = total + 1;
            if (bus.req_ready !== 1'b1) begin
                bad = bad + 1;
                $display("FAIL rmw_ready_c3[%0d]: got %0b want 1", i, bus.req_ready);
            end
            drain();
            total = total + 2;
            if (we_cnt - w0 !== 1) begin
                bad = bad + 1;
                $display("FAIL rmw_we_pulses[%0d]: got %0d want 1", i, we_cnt - w0);
            end
            if (mem[4] !== want[i]) begin
                bad = bad + 1;
                $display("FAIL rmw_mem[%0d]: got %08h want %08h", i, mem[4], want[i]);
            end
        end
    endtask

    task automatic test_errors();
        int w0;
        w0 = we_cnt;
        send(1'b0, 3'd2, 32'h12,   32'h0,         1'b1, 32'h0, 1);
        send(1'b1, 3'd1, 32'h13,   32'h0000_9999, 1'b1, 32'h0, 1);
        send(1'b0, 3'd3, 32'h10,   32'h0,         1'b1, 32'h0, 1);
        send(1'b1, 3'd2, 32'h1000, 32'h7777_7777, 1'b1, 32'h0, 1);
        send(1'b1, 3'd3, 32'h10,   32'h7777_7777, 1'b1, 32'h0, 1);
        send(1'b0, 3'd6, 32'h10,   32'h0,         1'b1, 32'h0, 1);
        drain();
        total = total + 2;
        if (we_cnt !== w0) begin
            bad = bad + 1;
            $display("FAIL err_no_write: got %0d writes want 0", we_cnt - w0);
        end
        if (mem[4] !== 32'h1234_AAEF) begin
            bad = bad + 1;
            $display("FAIL err_mem: got %08h want 1234aaef", mem[4]);
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        int r0;
        w0 = we_cnt;
        r0 = resp_cnt;
        send(1'b1, 3'd1, 32'h10, 32'h0000_5555, 1'b0, 32'h0, 3);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        total = total + 1;
        if (bus.mem_we !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL abort_mem_we: got %0b want 0", bus.mem_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total = total + 1;
        if (bus.req_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL abort_ready: got %0b want 1", bus.req_ready);
        end
        repeat (4) @(negedge clk);
        total = total + 3;
        if (we_cnt !== w0) begin
            bad = bad + 1;
            $display("FAIL abort_no_write: got %0d writes want 0", we_cnt - w0);
        end
        if (mem[4] !== 32'h1234_AAEF) begin
            bad = bad + 1;
            $display("FAIL abort_mem: got %08h want 1234aaef", mem[4]);
        end
        if (resp_cnt !== r0) begin
            bad = bad + 1;
            $display("FAIL abort_no_resp: got %0d responses want 0", resp_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = resp_cnt;
        send(1'b0, 3'd2, 32'h10, 32'h0,         1'b0, 32'h1234_AAEF, 2);
        send(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0,         1);
        send(1'b0, 3'd2, 32'h20, 32'h0,         1'b0, 32'hCAFE_F00D, 2);
        drain();
        total = total + 2;
        if (resp_cnt - r0 !== 3) begin
            bad = bad + 1;
            $display("FAIL b2b_resp_count: got %0d want 3", resp_cnt - r0);
        end
        if (mem[8] !== 32'hCAFE_F00D) begin
            bad = bad + 1;
            $display("FAIL b2b_mem: got %08h want cafef00d", mem[8]);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        we_cnt        = 0;
        resp_cnt      = 0;
        bus.mem_rdata = 32'h0;
        bus.req_valid = 1'b0;
        test_reset();
        test_sw_lw();
        test_load_ext();
        test_rmw();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
